// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution channel scheduler:
//   state_e        - scheduler state encoding (IDLE / ISSUE / DRAIN / OUT)
//   CONV_PIPE_LAT  - default issue-to-result latency of the 3x3 engine
//   CH_W           - width of a channel index / channel count
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_PIPE_LAT = 3;
    localparam int CH_W          = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/conv_valid_pipe.sv
// ---------------------------------------------------------------------------
// conv_valid_pipe
// DEPTH-stage shift register that follows each issued channel through the
// engine latency, carrying the channel index the engine is expected to
// return alongside it.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (clears all valids)
//   in_vld_i      - a channel is issued this cycle
//   in_tag_i      - index of the issued channel
//   out_vld_o     - the tracked issue emerges (engine result is due now)
//   out_tag_o     - expected channel index for the emerging result
//   out_last_o    - the emerging entry is the only one still in flight
// ---------------------------------------------------------------------------
module conv_valid_pipe #(
    parameter int DEPTH = 3,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_vld_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_last_o
);

    // Only the output stage occupied: nothing else is in flight.
    localparam logic [DEPTH-1:0] LAST_ONLY = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            tag_q[0] <= in_tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_vld_o  = vld_q[DEPTH-1];
    assign out_tag_o  = tag_q[DEPTH-1];
    assign out_last_o = (vld_q == LAST_ONLY);

endmodule

// File: rtl/conv_channel_scheduler.sv
// ---------------------------------------------------------------------------
// conv_channel_scheduler
// Sequences the input channels of one output pixel through a pipelined 3x3
// compute engine and accumulates the per-channel results.
// Optional build macro: CONV_SCHED_RELU_EN - clamp the pixel at zero (ReLU)
// when it is captured for output.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin one pixel (accepted only when idle)
//   num_channels    - channel count, latched on an accepted start
//   src_valid       - operand buffer holds data for ch_sel
//   ch_sel          - channel index to operand buffer / engine
//   issue           - engine inputs valid, channel ch_sel consumed
//   ce_result       - engine result (signed, 2*DATA_WIDTH)
//   ce_ch           - channel tag returned by the engine
//   out_data        - accumulated pixel (signed, ACC_WIDTH)
//   out_valid/ready - output handshake
//   busy            - scheduler not idle
//   tag_err         - sticky channel-tag mismatch flag
// ACC_WIDTH is expected to be at least 2*DATA_WIDTH+8.
// ---------------------------------------------------------------------------
module conv_channel_scheduler
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int PIPE_LAT   = CONV_PIPE_LAT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CH_W-1:0]                num_channels,
    input  logic                           src_valid,
    output logic [CH_W-1:0]                ch_sel,
    output logic                           issue,
    input  logic signed [2*DATA_WIDTH-1:0] ce_result,
    input  logic [CH_W-1:0]                ce_ch,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           tag_err
);

    state_e                      state_q, state_d;
    logic [CH_W-1:0]             num_q, num_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] out_q, out_d;
    logic                        tag_err_q, tag_err_d;

    logic                        pv_vld, pv_last;
    logic [CH_W-1:0]             pv_tag;
    logic                        last_issue;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] pix_val;

    conv_valid_pipe #(
        .DEPTH (PIPE_LAT),
        .TAG_W (CH_W)
    ) u_vpipe (
        .clk        (clk),
        .rst        (rst),
        .in_vld_i   (issue),
        .in_tag_i   (ch_q),
        .out_vld_o  (pv_vld),
        .out_tag_o  (pv_tag),
        .out_last_o (pv_last)
    );

    // Signed size cast sign-extends the engine result; the add wraps.
    assign acc_sum    = acc_q + ACC_WIDTH'(ce_result);
    assign last_issue = (ch_q == num_q - CH_W'(1));

    // The pixel is captured on the edge that accumulates the final result,
    // so it is taken from the running sum rather than the registered acc.
`ifdef CONV_SCHED_RELU_EN
    assign pix_val = acc_sum[ACC_WIDTH-1] ? '0 : acc_sum;
`else
    assign pix_val = acc_sum;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            tag_err_q <= tag_err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (num_channels == '0) ? S_OUT : S_ISSUE;
            S_ISSUE: if (issue && last_issue) state_d = S_DRAIN;
            S_DRAIN: if (pv_vld && pv_last) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        num_d     = num_q;
        ch_d      = ch_q;
        acc_d     = acc_q;
        out_d     = out_q;
        tag_err_d = tag_err_q;
        if (state_q == S_IDLE && start) begin
            num_d = num_channels;
            ch_d  = '0;
            acc_d = '0;
            if (num_channels == '0) out_d = '0;
        end else begin
            if (issue) ch_d = ch_q + CH_W'(1);
            // A mismatching tag is flagged but the result still counts.
            if (pv_vld) begin
                acc_d = acc_sum;
                if (pv_tag != ce_ch) tag_err_d = 1'b1;
            end
            if (state_q == S_DRAIN && pv_vld && pv_last) out_d = pix_val;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        issue     = (state_q == S_ISSUE) && src_valid;
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_OUT);
    end

    assign ch_sel   = ch_q;
    assign out_data = out_q;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_channel_scheduler
// Directed + randomized bench. The 3x3 engine is modelled as a PL-deep delay
// line fed by issue/ch_sel; expected pixels are plain sums of the per-channel
// result table, expected timing follows from the src_valid pattern driven.
// ---------------------------------------------------------------------------
module tb_conv_channel_scheduler;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int PL = 3;

    logic                   clk = 1'b0;
    logic                   rst, start, src_valid, out_ready;
    logic [7:0]             num_channels, ch_sel, ce_ch;
    logic                   issue, out_valid, busy, tag_err;
    logic signed [2*DW-1:0] ce_result;
    logic signed [AW-1:0]   out_data;

    int checks   = 0;
    int failures = 0;

    logic signed [2*DW-1:0] res_tbl [256];
    int                     bad_ch = -1;
    bit                     exp_tag;

    logic [7:0]             e_ch  [PL];
    logic signed [2*DW-1:0] e_res [PL];

    always #5 clk = ~clk;

    conv_channel_scheduler #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .PIPE_LAT   (PL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_channels (num_channels),
        .src_valid    (src_valid),
        .ch_sel       (ch_sel),
        .issue        (issue),
        .ce_result    (ce_result),
        .ce_ch        (ce_ch),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .tag_err      (tag_err)
    );

    // Engine model: not reset, so results of an aborted pixel keep arriving.
    always @(posedge clk) begin
        e_ch[0]  <= (int'(ch_sel) == bad_ch) ? (ch_sel ^ 8'h01) : ch_sel;
        e_res[0] <= res_tbl[ch_sel];
        for (int i = 1; i < PL; i++) begin
            e_ch[i]  <= e_ch[i-1];
            e_res[i] <= e_res[i-1];
        end
    end

    assign ce_result = e_res[PL-1];
    assign ce_ch     = e_ch[PL-1];

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel: start at the current cycle, drive src_valid from sv_mask
    // (bit k = cycle k after start, 1 beyond bit 63), hold out_ready low for
    // rdy_dly cycles of OUT, optionally poke start while waiting.
    task automatic run_pixel(input string nm, input int n, input logic [63:0] sv_mask,
                             input int rdy_dly, input bit poke_start);
        int   cyc, ones, exp_last, exp_ov, ov_cyc, issues, exp_sum;
        logic exp_iss;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum += int'(res_tbl[i]);
`ifdef CONV_SCHED_RELU_EN
        if (exp_sum < 0) exp_sum = 0;
`endif
        if (bad_ch >= 0 && bad_ch < n) exp_tag = 1'b1;

        start = 1'b1; num_channels = 8'(n); src_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; ones = 0; exp_last = 0; ov_cyc = -1; issues = 0;
        while (cyc < 2000) begin
            src_valid = (cyc < 64) ? sv_mask[cyc] : 1'b1;
            #2;
            exp_iss = (ones < n) ? src_valid : 1'b0;
            if (ones < n && src_valid) begin
                ones++;
                if (ones == n) exp_last = cyc;
            end
            if (out_valid) begin
                ov_cyc = cyc;
                break;
            end
            chk({nm, "/issue"}, issue, exp_iss);
            if (issue) begin
                chk({nm, "/ch_sel"}, ch_sel, issues);
                issues++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        exp_ov = (n == 0) ? 1 : exp_last + PL + 1;
        chk({nm, "/issue_count"}, issues, n);
        chk({nm, "/out_valid_cycle"}, ov_cyc, exp_ov);
        if (ov_cyc < 0) return;

        for (int d = 0; d < rdy_dly; d++) begin
            chk({nm, "/hold_valid"}, out_valid, 1);
            chk({nm, "/hold_data"}, out_data, exp_sum);
            chk({nm, "/hold_busy"}, busy, 1);
            start = poke_start && (d == 1);
            num_channels = 8'd5;
            @(posedge clk); #1;
            start = 1'b0;
            #2;
        end
        chk({nm, "/out_valid"}, out_valid, 1);
        chk({nm, "/out_data"}, out_data, exp_sum);
        chk({nm, "/tag_err"}, tag_err, exp_tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; src_valid = 1'b0;
        #2;
        chk({nm, "/post_valid"}, out_valid, 0);
        chk({nm, "/post_busy"}, busy, 0);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "/ch_sel"}, ch_sel, 0);
        chk({nm, "/issue"}, issue, 0);
        chk({nm, "/out_valid"}, out_valid, 0);
        chk({nm, "/out_data"}, out_data, 0);
        chk({nm, "/busy"}, busy, 0);
        chk({nm, "/tag_err"}, tag_err, 0);
    endtask

    initial begin
        logic [63:0] mask;
        int          n, dly;
        bit          poke;

        rst = 1'b1; start = 1'b0; num_channels = '0; src_valid = 1'b0;
        out_ready = 1'b0; exp_tag = 1'b0;
        for (int i = 0; i < 256; i++) res_tbl[i] = '0;
        for (int i = 0; i < PL; i++) begin
            e_ch[i]  = '0;
            e_res[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid = 1'b1;   // must not issue while idle
        #2;
        check_reset_state("reset");

        // Basic three-channel pixel: 10 - 4 + 7 = 13, out_valid at cycle 7
        res_tbl[0] = 16'sd10; res_tbl[1] = -16'sd4; res_tbl[2] = 16'sd7;
        run_pixel("nc3", 3, '1, 0, 1'b0);

        // Zero channels: straight to OUT with 0
        run_pixel("nc0", 0, '1, 1, 1'b0);

        // Two-cycle stall after the second issue
        for (int i = 0; i < 4; i++) res_tbl[i] = 16'($urandom);
        run_pixel("stall", 4, ~64'h18, 0, 1'b0);

        // Back-pressure for 5 cycles with a start poked in the window
        for (int i = 0; i < 3; i++) res_tbl[i] = 16'($urandom);
        run_pixel("bp", 3, '1, 5, 1'b1);

        // Reset two cycles into an 8-channel pixel
        for (int i = 0; i < 8; i++) res_tbl[i] = 16'sd1000;
        start = 1'b1; num_channels = 8'd8; src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_tag = 1'b0;
        #2;
        check_reset_state("abort");
        res_tbl[0] = 16'sd5; res_tbl[1] = 16'sd6;
        run_pixel("after_abort", 2, '1, 0, 1'b0);

        // Wrong tag on channel 1; flag is sticky across the next pixel
        bad_ch = 1;
        res_tbl[0] = -16'sd20; res_tbl[1] = 16'sd5;
        run_pixel("tag", 2, '1, 0, 1'b0);
        bad_ch = -1;
        for (int i = 0; i < 3; i++) res_tbl[i] = 16'($urandom);
        run_pixel("tag_sticky", 3, '1, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_tag = 1'b0;
        #2;
        chk("tag_cleared", tag_err, 0);

        // Largest channel count
        for (int i = 0; i < 255; i++) res_tbl[i] = 16'($urandom);
        run_pixel("nc255", 255, '1, 0, 1'b0);

        // Randomized pixels
        for (int t = 0; t < 12; t++) begin
            n    = $urandom_range(0, 24);
            mask = {$urandom, $urandom} | {$urandom, $urandom};
            dly  = $urandom_range(0, 3);
            poke = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) res_tbl[i] = 16'($urandom);
            run_pixel("rand", n, mask, dly, poke);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
